// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-issue stage directly ahead of the ALU.
// Owns the architectural register file, its write-back port and a per-register
// busy scoreboard that stalls issue on read-after-write hazards. Operands are
// presented to the ALU through a one-deep registered output with valid/ready.
// Optional feature macro: ALU_OPSTAGE_BYPASS_EN -- when defined, a write-back
// landing this cycle is forwarded into operand read and releases the hazard in
// the same cycle; when undefined, the dependent op waits one extra cycle.
module alu_operand_stage #(
  parameter int WORD_LEN   = 32,
  parameter int REG_COUNT  = 32,
  localparam int RW        = $clog2(REG_COUNT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RW-1:0]       in_rs1,
  input  logic [RW-1:0]       in_rs2,
  input  logic [RW-1:0]       in_rd,
  input  logic [WORD_LEN-1:0] in_imm,
  input  logic                in_use_imm,
  input  logic [3:0]          in_op_select,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_LEN-1:0] out_a,
  output logic [WORD_LEN-1:0] out_b,
  output logic [3:0]          out_op_select,
  output logic [RW-1:0]       out_rd,
  input  logic                wb_en,
  input  logic [RW-1:0]       wb_rd,
  input  logic [WORD_LEN-1:0] wb_data
);

  // Architectural state. Entry 0 is never written, so it stays at its reset
  // value of zero and register 0 reads 0 without a special read-side case.
  logic [WORD_LEN-1:0]  regfile_reg [REG_COUNT];
  logic [REG_COUNT-1:0] busy_reg;

  // Registered ALU-facing outputs.
  logic                 out_valid_reg;
  logic [WORD_LEN-1:0]  out_a_reg;
  logic [WORD_LEN-1:0]  out_b_reg;
  logic [3:0]           out_op_reg;
  logic [RW-1:0]        out_rd_reg;

  // One-hot decodes of this cycle's write-back target and newly-busy target.
  logic [REG_COUNT-1:0] wb_hit;
  logic [REG_COUNT-1:0] set_hit;

  logic                 fwd_a;
  logic                 fwd_b;
  logic                 blk_a;
  logic                 blk_b;
  logic                 hazard;
  logic                 accept;
  logic [WORD_LEN-1:0]  opnd_a;
  logic [WORD_LEN-1:0]  opnd_b;

  // Per-register decode; register 0 never matches, which both discards writes
  // to it and keeps it out of the scoreboard.
  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_dec
      if (gi == 0) begin : g_zero
        assign wb_hit[gi]  = 1'b0;
        assign set_hit[gi] = 1'b0;
      end else begin : g_nz
        assign wb_hit[gi]  = wb_en  && (wb_rd == RW'(gi));
        assign set_hit[gi] = accept && (in_rd == RW'(gi));
      end
    end
  endgenerate

`ifdef ALU_OPSTAGE_BYPASS_EN
  // A source being written back this cycle takes the write-back value and is
  // no longer considered pending.
  assign fwd_a = wb_hit[in_rs1];
  assign fwd_b = wb_hit[in_rs2];
`else
  // No forwarding: a pending source must wait until the register file holds it.
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign blk_a  = busy_reg[in_rs1] && !fwd_a;
  assign blk_b  = !in_use_imm && busy_reg[in_rs2] && !fwd_b;
  assign hazard = in_valid && (blk_a || blk_b);

  // Ready depends only on output occupancy and the hazard, never on itself.
  assign in_ready = (!out_valid_reg || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  assign opnd_a = fwd_a ? wb_data : regfile_reg[in_rs1];
  assign opnd_b = in_use_imm ? in_imm
                : (fwd_b ? wb_data : regfile_reg[in_rs2]);

  // Register file: write-back port, register 0 excluded by the decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regfile_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wb_hit[i]) begin
          regfile_reg[i] <= wb_data;
        end
      end
    end
  end

  // Scoreboard: write-back clears, a newly issued destination sets; when both
  // hit the same register the set wins because the newer result is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= (busy_reg & ~wb_hit) | set_hit;
    end
  end

  // Output register: load on accept, otherwise drain on ready and hold data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_op_reg    <= '0;
      out_rd_reg    <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_a_reg     <= opnd_a;
      out_b_reg     <= opnd_b;
      out_op_reg    <= in_op_select;
      out_rd_reg    <= in_rd;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid     = out_valid_reg;
  assign out_a         = out_a_reg;
  assign out_b         = out_b_reg;
  assign out_op_select = out_op_reg;
  assign out_rd        = out_rd_reg;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Operand-issue stage directly upstream of the ALU. It accepts decoded operations over a valid/ready handshake and reads rs1/rs2 from an internal register file. It selects an immediate for operand b when requested, and presents registered a/b/op_select to the ALU. It also owns the register-file write-back port fed by the ALU result, plus a per-register busy scoreboard that stalls issue on read-after-write hazards.

Parameters:
WORD_LEN, 32, datapath width; matches the ALU word length.
REG_COUNT, 32, number of architectural registers; power of two; register index width RW = $clog2(REG_COUNT).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream operation valid.
in_ready  output  1  stage can accept this cycle.
in_rs1  input  RW  source register for operand a.
in_rs2  input  RW  source register for operand b.
in_rd  input  RW  destination register; 0 means no write-back expected.
in_imm  input  WORD_LEN  immediate value.
in_use_imm  input  1  1: b = in_imm, rs2 is not read and not hazard-checked.
in_op_select  input  4  ALU operation code, passed through unchanged.
out_valid  output  1  a/b/op_select/rd valid toward ALU.
out_ready  input  1  downstream consumes this cycle.
out_a  output  WORD_LEN  ALU operand a.
out_b  output  WORD_LEN  ALU operand b.
out_op_select  output  4  registered op code.
out_rd  output  RW  registered destination.
wb_en  input  1  write-back strobe from the ALU result path.
wb_rd  input  RW  write-back register.
wb_data  input  WORD_LEN  write-back value (ALU result).

Behaviour:
- Reset (rst_n low, asynchronous):
  - all register-file entries = 0 and all busy bits = 0.
  - out_valid = 0; out_a, out_b, out_rd = 0; out_op_select = 0.
  - Reset mid-operation discards any held output and any pending busy state.
- Register 0 always reads 0. It is never marked busy, and writes to it are ignored.
- Write-back: when wb_en = 1 and wb_rd != 0, regfile[wb_rd] <= wb_data and busy[wb_rd] <= 0 at the clock edge.
- Hazard: the stage is blocked when in_valid = 1 and busy[in_rs1] = 1, or when in_use_imm = 0 and busy[in_rs2] = 1.
  - A busy source that is being written back this cycle (wb_en = 1, wb_rd matches) is not blocked; its value comes via bypass.
- in_ready = (!out_valid || out_ready) && !hazard. It is purely combinational and does not depend on in_ready itself.
- Accept (in_valid && in_ready) at edge:
  - out_a <= operand(rs1); out_b <= in_use_imm ? in_imm : operand(rs2).
  - out_op_select, out_rd, out_valid <= 1 are registered.
  - Latency is 1 cycle from accept to out_valid.
  - operand(r) = wb_data if (wb_en && wb_rd == r && r != 0), otherwise regfile[r] (0 for r = 0).
- When in_rd != 0 is accepted, busy[in_rd] <= 1.
  - If the same edge also clears busy[in_rd] via write-back, the set wins (the newer write is pending).
- Output hold: while out_valid && !out_ready, all out_* are held stable.
- Output drain: when out_ready && !accept, out_valid <= 0 and the data outputs hold their last values.
- Back-to-back: accept and drain in the same cycle sustain one operation per cycle.
- The ALU result is written back later by external logic; this stage places no ordering assumption on write-back timing beyond the busy bits.

Optional Feature:
ALU_OPSTAGE_BYPASS_EN.
- Defined: same-cycle write-back bypass as described above. A dependent op issues in the same cycle as its producer's write-back.
- Undefined: no bypass path.
  - operand(r) = regfile[r] only.
  - A source whose busy bit is set blocks issue even when wb matches this cycle.
  - The dependent op issues the following cycle, one extra stall cycle per RAW hazard.
  - All other behaviour is identical.

Test Plan:
- Reset then idle -> out_valid = 0 and in_ready = 1. Issue rs1 = 0, rs2 = 0, in_use_imm = 0, op 8, rd = 0 with out_ready = 1 -> next cycle out_a = 0, out_b = 0, out_op_select = 8, out_valid = 1.
- wb_en = 1, wb_rd = 5, wb_data = 0x1234. Next cycle issue rs1 = 5, in_use_imm = 1, in_imm = 0x10, rd = 0 -> out_a = 0x1234, out_b = 0x10.
- Issue rd = 3, then issue rs1 = 3 with no wb -> in_ready = 0, held indefinitely. Assert wb_en, wb_rd = 3, wb_data = 0xAA -> with BYPASS_EN, accepted that cycle with out_a = 0xAA. Without BYPASS_EN, accepted the next cycle with out_a = 0xAA.
- out_ready = 0 with out_valid = 1 -> in_ready = 0 and out_a/out_b stable for 4 cycles. Then out_ready = 1 with a new in_valid -> drain and accept in the same cycle, no bubble.
- Write to register 0 (wb_rd = 0, wb_data = 0xFFFF), then issue rs1 = 0, rd = 0 -> out_a = 0, never stalls.
- Issue rd = 7 (busy), then drop rst_n mid-cycle -> outputs clear immediately. After release, issue rs1 = 7 -> no stall, out_a = 0.
